// File: rtl/pipeline_id_ex_skid.sv
// ---------------------------------------------------------------------------
// pipeline_id_ex_skid
//
// This is the ID/EX pipeline register for the RISC core. It sits between
// decode/register-read and execute. It uses a valid/ready handshake and holds
// two entries: a main entry M and a skid entry S. Because of the skid entry,
// in_ready comes straight from a flop, and there is no combinational path
// from out_ready back to the decode stage.
//
// Behaviour:
//   - flush kills every entry in flight.
//   - Control outputs are gated to zero during bubbles.
//   - A saturating counter records the cycles in which execute stalled.
//
// Parameters:
//   DATA_W  width of the a/b/pc2/ea operand fields
//   RA_W    destination register address width
//   CTRL_W  packed control bundle width. Fields, MSB to LSB:
//           ex_lr_en, ex_brx, ex_alu_sel[3:0], ex_br_sel[1:0],
//           mem_wr_en, mem_imm_sel, wb_wb_sel, wb_data_sel, wb_reg_en
//   CNT_W   stall counter width
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   decode stage offers an instruction
//   in_ready   this block can take an instruction this cycle (flop output)
//   a_in, b_in, pc2_in, ea_in, ra_in, ctrl_in   incoming payload
//   out_valid  execute-stage payload is valid
//   out_ready  execute stage consumes the payload this cycle
//   a_out, b_out, pc2_out, ea_out, ra_out       outgoing payload (not gated)
//   ctrl_out   control bundle, forced to zero while out_valid is low
//   flush      drops every entry in flight
//   clr_stats  clears stall_cnt
//   stall_cnt  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_id_ex_skid #(
   parameter int DATA_W = 8,
   parameter int RA_W   = 2,
   parameter int CTRL_W = 13,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic [DATA_W-1:0] pc2_in,
   input  logic [DATA_W-1:0] ea_in,
   input  logic [RA_W-1:0]   ra_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] pc2_out,
   output logic [DATA_W-1:0] ea_out,
   output logic [RA_W-1:0]   ra_out,
   output logic [CTRL_W-1:0] ctrl_out,
   input  logic              flush,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PAY_W = 4 * DATA_W + RA_W + CTRL_W;

   logic              m_valid;
   logic              s_valid;
   logic [PAY_W-1:0]  m_pay;
   logic [PAY_W-1:0]  s_pay;
   logic [PAY_W-1:0]  in_pay;
   logic [CTRL_W-1:0] m_ctrl;
   logic              accept;
   logic              drain;

   // Pack the whole payload into one vector, so that moving an entry between
   // M and S is a single assignment and no field can be left behind.
   assign in_pay = {a_in, b_in, pc2_in, ea_in, ra_in, ctrl_in};

   assign in_ready  = !s_valid;
   assign out_valid = m_valid;
   assign accept    = in_valid & in_ready;
   assign drain     = !m_valid | out_ready;

   // Entry storage. The branches are in priority order: reset, then flush,
   // then refill M from S, then refill M from the input, then park the input
   // in S.
   // - flush only clears the valid bits. The payload keeps its old contents,
   //   because the data outputs are allowed to show stale values.
   // - When M drains and S is empty, M always loads the input payload.
   //   m_valid follows accept, so a bubble carries whatever data was on the
   //   input bus.
   // - S is written only when M is stalled. S is therefore always the younger
   //   entry, and it moves into M before anything new can be accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_pay   <= '0;
         s_pay   <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (drain && s_valid) begin
         m_pay   <= s_pay;
         m_valid <= 1'b1;
         s_valid <= 1'b0;
      end else if (drain) begin
         m_pay   <= in_pay;
         m_valid <= accept;
      end else if (accept) begin
         s_pay   <= in_pay;
         s_valid <= 1'b1;
      end
   end

   // Unpack M onto the outputs. The control bundle is gated so that an empty
   // or flushed stage never drives write enables or branch controls into
   // execute.
   assign {a_out, b_out, pc2_out, ea_out, ra_out, m_ctrl} = m_pay;
   assign ctrl_out = m_valid ? m_ctrl : '0;

   // Performance counter. It counts a cycle when execute holds off a valid
   // instruction, and sticks at all-ones instead of wrapping.
   // - It ignores flush, so a flush in a stalled cycle is still counted.
   // - clr_stats takes priority over an increment in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (clr_stats) begin
         stall_cnt <= '0;
      end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_id_ex_skid.sv
// ---------------------------------------------------------------------------
// tb_pipeline_id_ex_skid
//
// Self-checking bench for pipeline_id_ex_skid. The DUT is built with
// CNT_W=4 so that counter saturation is reachable quickly.
//
// The bench runs directed sequences with hand-computed expectations:
//   - reset
//   - streaming
//   - skid/backpressure
//   - flush
//   - reset mid-stream
//   - saturation and clear
//
// It then runs a randomised phase. In that phase a queue model of the two
// entries predicts ordering, readiness and the stall count.
// ---------------------------------------------------------------------------
module tb_pipeline_id_ex_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a_in, b_in, pc2_in, ea_in;
   logic [1:0]  ra_in;
   logic [12:0] ctrl_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  a_out, b_out, pc2_out, ea_out;
   logic [1:0]  ra_out;
   logic [12:0] ctrl_out;
   logic        flush;
   logic        clr_stats;
   logic [3:0]  stall_cnt;

   int total = 0;
   int bad   = 0;

   pipeline_id_ex_skid #(
      .DATA_W(8), .RA_W(2), .CTRL_W(13), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .pc2_in(pc2_in), .ea_in(ea_in),
      .ra_in(ra_in), .ctrl_in(ctrl_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .a_out(a_out), .b_out(b_out), .pc2_out(pc2_out), .ea_out(ea_out),
      .ra_out(ra_out), .ctrl_out(ctrl_out),
      .flush(flush), .clr_stats(clr_stats), .stall_cnt(stall_cnt)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   // Every comparison goes through this task, so the pass/fail counts stay
   // consistent.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs. The other operand fields are derived from a,
   // so a single byte identifies each instruction.
   task automatic applyStimulus(input logic v, input logic [7:0] a,
                                input logic [12:0] c, input logic ordy,
                                input logic fl, input logic clr);
      in_valid  = v;
      a_in      = a;
      b_in      = ~a;
      pc2_in    = a + 8'd1;
      ea_in     = a ^ 8'h5A;
      ra_in     = a[1:0];
      ctrl_in   = c;
      out_ready = ordy;
      flush     = fl;
      clr_stats = clr;
   endtask

   // Advance one clock edge. Outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [20:0] q[$];
   logic [20:0] front;
   logic [7:0]  seq;
   logic [3:0]  exp_cnt;
   logic        rv, rordy, rfl, rclr, push_ok;
   logic [12:0] rc;

   initial begin
      // Reset held low with a valid input offered: nothing may be captured.
      rst = 1'b0;
      applyStimulus(1'b1, 8'h99, 13'h1FFF, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
      checkOutput("rst_ctrl_out",  32'(ctrl_out),  32'd0);
      checkOutput("rst_a_out",     32'(a_out),     32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("rst_rel_out_valid", 32'(out_valid), 32'd0);

      // Streaming at full throughput.
      applyStimulus(1'b1, 8'h10, 13'h0A5, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("str0_valid", 32'(out_valid), 32'd1);
      checkOutput("str0_a",     32'(a_out),     32'h10);
      checkOutput("str0_ctrl",  32'(ctrl_out),  32'h0A5);
      applyStimulus(1'b1, 8'h11, 13'h0A5, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("str1_valid", 32'(out_valid), 32'd1);
      checkOutput("str1_a",     32'(a_out),     32'h11);
      checkOutput("str1_b",     32'(b_out),     32'hEE);
      applyStimulus(1'b1, 8'h12, 13'h0A5, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("str2_valid", 32'(out_valid), 32'd1);
      checkOutput("str2_a",     32'(a_out),     32'h12);
      checkOutput("str2_pc2",   32'(pc2_out),   32'h13);
      checkOutput("str2_ea",    32'(ea_out),    32'h48);
      checkOutput("str2_ra",    32'(ra_out),    32'h2);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("str_end_valid", 32'(out_valid), 32'd0);
      checkOutput("str_end_ctrl",  32'(ctrl_out),  32'd0);
      checkOutput("str_end_cnt",   32'(stall_cnt), 32'd0);

      // Skid and backpressure.
      applyStimulus(1'b1, 8'h20, 13'h001, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("skid_m_a", 32'(a_out), 32'h20);
      applyStimulus(1'b1, 8'h21, 13'h002, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("skid_st1_a",     32'(a_out),     32'h20);
      checkOutput("skid_st1_ready", 32'(in_ready),  32'd0);
      checkOutput("skid_st1_cnt",   32'(stall_cnt), 32'd1);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("skid_st2_a", 32'(a_out), 32'h20);
      tick();
      checkOutput("skid_st3_a",     32'(a_out),     32'h20);
      checkOutput("skid_st3_cnt",   32'(stall_cnt), 32'd3);
      checkOutput("skid_st3_ready", 32'(in_ready),  32'd0);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("skid_rel_a",     32'(a_out),     32'h21);
      checkOutput("skid_rel_valid", 32'(out_valid), 32'd1);
      checkOutput("skid_rel_ctrl",  32'(ctrl_out),  32'h002);
      checkOutput("skid_rel_ready", 32'(in_ready),  32'd1);
      checkOutput("skid_rel_cnt",   32'(stall_cnt), 32'd3);
      tick();
      checkOutput("skid_empty_valid", 32'(out_valid), 32'd0);

      // Flush with both entries full while a new input is offered.
      applyStimulus(1'b1, 8'h40, 13'h1FFF, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h41, 13'h1FFF, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("fl_pre_ready", 32'(in_ready), 32'd0);
      checkOutput("fl_pre_ctrl",  32'(ctrl_out), 32'h1FFF);
      applyStimulus(1'b1, 8'h30, 13'h1FFF, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("fl_valid", 32'(out_valid), 32'd0);
      checkOutput("fl_ctrl",  32'(ctrl_out),  32'd0);
      checkOutput("fl_ready", 32'(in_ready),  32'd1);
      checkOutput("fl_a_keep", 32'(a_out),    32'h40);
      checkOutput("fl_cnt",   32'(stall_cnt), 32'd5);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("fl_after_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h50, 13'h010, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("fl_new_valid", 32'(out_valid), 32'd1);
      checkOutput("fl_new_a",     32'(a_out),     32'h50);

      // Reset mid-stream, with M and S both full.
      applyStimulus(1'b1, 8'h60, 13'h1FFF, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h61, 13'h1FFF, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("mr_pre_ready", 32'(in_ready),  32'd0);
      checkOutput("mr_pre_cnt",   32'(stall_cnt), 32'd6);
      rst = 1'b0;
      applyStimulus(1'b1, 8'h62, 13'h1FFF, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("mr_valid", 32'(out_valid), 32'd0);
      checkOutput("mr_ready", 32'(in_ready),  32'd1);
      checkOutput("mr_a",     32'(a_out),     32'd0);
      checkOutput("mr_ctrl",  32'(ctrl_out),  32'd0);
      checkOutput("mr_cnt",   32'(stall_cnt), 32'd0);
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("mr_rel_valid", 32'(out_valid), 32'd0);

      // Counter saturation, then clear during a stall.
      applyStimulus(1'b1, 8'h70, 13'h004, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      checkOutput("sat_cnt",   32'(stall_cnt), 32'd15);
      checkOutput("sat_hold_a", 32'(a_out),    32'h70);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("clr_cnt", 32'(stall_cnt), 32'd0);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("clr_next_cnt", 32'(stall_cnt), 32'd1);
      applyStimulus(1'b0, 8'h00, 13'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("sat_drain_valid", 32'(out_valid), 32'd0);
      checkOutput("sat_drain_cnt",   32'(stall_cnt), 32'd1);

      // Randomised ordering check against a queue model of the two entries.
      exp_cnt = 4'd1;
      seq     = 8'h80;
      for (int i = 0; i < 10000; i++) begin
         rv    = ($urandom_range(0, 3) != 0);
         rordy = ($urandom_range(0, 9) < 7);
         rfl   = ($urandom_range(0, 63) == 0);
         rclr  = ($urandom_range(0, 255) == 0);
         rc    = 13'($urandom);
         applyStimulus(rv, seq, rc, rordy, rfl, rclr);
         if (rclr) exp_cnt = 4'd0;
         else if ((q.size() > 0) && !rordy && (exp_cnt != 4'd15))
            exp_cnt = exp_cnt + 4'd1;
         if (rfl) begin
            q.delete();
         end else begin
            push_ok = rv && (q.size() < 2);
            if ((q.size() > 0) && rordy) void'(q.pop_front());
            if (push_ok) begin
               q.push_back({rc, seq});
               seq = seq + 8'd1;
            end
         end
         tick();
         checkOutput("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
         checkOutput("rnd_ready", 32'(in_ready),  32'(q.size() < 2));
         checkOutput("rnd_cnt",   32'(stall_cnt), 32'(exp_cnt));
         if (q.size() > 0) begin
            front = q[0];
            checkOutput("rnd_a",    32'(a_out),    32'(front[7:0]));
            checkOutput("rnd_ctrl", 32'(ctrl_out), 32'(front[20:8]));
         end else begin
            checkOutput("rnd_bubble_ctrl", 32'(ctrl_out), 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_id_ex_skid.md
# pipeline_id_ex_skid

Parametrised ID/EX pipeline register for the RISC core. It adds a valid/ready handshake with a two-entry skid buffer, so stalls do not need a combinational ready path. It also adds a flush input that inserts bubbles, bubble gating of every control output, and a saturating stall counter for performance monitoring. It sits between the decode/register-read stage and the execute stage.

## Interface
- DATA_W, 8: width of A, B, PC2 and ea operand fields.
- RA_W, 2: destination register address width.
- CTRL_W, 13: packed control bundle width. Bit order, MSB to LSB:
  - ex_lr_en, ex_brx, ex_alu_sel[3:0], ex_br_sel[1:0]
  - mem_wr_en, mem_imm_sel
  - wb_wb_sel, wb_data_sel, wb_reg_en
- CNT_W, 8: stall counter width.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-low. Asserted when rst=0 at a clk rising edge.
- in_valid  in  1  decode stage presents a valid instruction.
- in_ready  out  1  block can accept this cycle. Driven directly from a flop.
- a_in, b_in, pc2_in, ea_in  in  DATA_W each  operand payload.
- ra_in  in  RA_W  destination register.
- ctrl_in  in  CTRL_W  control bundle.
- out_valid  out  1  execute-stage payload is valid.
- out_ready  in  1  execute stage consumes this cycle.
- a_out, b_out, pc2_out, ea_out, ra_out  out  payload registers.
- ctrl_out  out  CTRL_W  control bundle, forced to 0 whenever out_valid=0.
- flush  in  1  branch/exception kill of all in-flight entries.
- clr_stats  in  1  clears stall_cnt.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Storage:
  - Main entry M (m_valid plus payload) drives all outputs.
  - Skid entry S (s_valid plus payload) holds one extra instruction.
  - out_valid = m_valid.
  - in_ready = !s_valid.
- accept = in_valid & in_ready.
- drain = !m_valid | out_ready.
- Per-edge priority, highest first:
  1. rst=0: m_valid, s_valid, all payload, stall_cnt <= 0.
  2. flush=1: m_valid <= 0 and s_valid <= 0. Any input offered this cycle is dropped. Payload registers keep their values.
  3. drain and s_valid: M <= S, s_valid <= 0. An input is not accepted, because in_ready=0.
  4. drain and !s_valid: M <= input, m_valid <= accept.
  5. !drain and accept: S <= input, s_valid <= 1.
  6. Otherwise: hold.
- Ordering: S is always younger than M. Entries are never reordered or duplicated.
- Bubble gating: ctrl_out = m_valid ? m_ctrl : 0. A flushed or empty stage therefore never asserts mem_wr_en, wb_reg_en, ex_lr_en or ex_brx downstream.
- Data outputs are not gated. They hold stale values while out_valid=0.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - clr_stats wins over an increment in the same cycle.
  - flush does not clear it.
- Flush and stall in the same cycle: flush wins. Both entries are emptied and the counter still increments for that cycle's stall.

## Timing
- Reset values, with rst=0 seen at an edge:
  - out_valid=0, in_ready=1, ctrl_out=0.
  - All data outputs 0, stall_cnt=0.
  - While rst is held low, no input is captured even though in_ready reads 1.
- Latency: 1 cycle. An input accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 instruction per cycle while out_ready stays 1.
- Backpressure:
  - The first stalled cycle absorbs one extra instruction into S.
  - in_ready falls the cycle after S fills.
  - in_ready rises the cycle after S drains into M.
- in_ready depends only on flops. There is no combinational path from out_ready to in_ready.
- After flush: out_valid=0 and in_ready=1 on the next cycle. A new accept is possible on the following edge.

## Test plan
- Reset mid-stream:
  - Stimulus: with M and S both full, drive rst=0 for 1 cycle.
  - Required: out_valid=0, in_ready=1, a_out=0, ctrl_out=0, stall_cnt=0.
- Streaming:
  - Stimulus: out_ready=1; send a_in = 0x10, 0x11, 0x12 on consecutive cycles.
  - Required: a_out shows 0x10, 0x11, 0x12 one cycle later each, with out_valid continuously 1.
- Skid and backpressure:
  - Stimulus: send 0x20 then 0x21; drop out_ready after 0x20 is in M; hold it low 3 cycles, then raise it.
  - Required:
    - 0x21 lands in S and in_ready goes 0.
    - a_out stays 0x20 for 3 cycles, then shows 0x21.
    - in_ready returns to 1.
    - stall_cnt=3.
- Flush with bubble:
  - Stimulus: fill M and S with ctrl_in=13'h1FFF; pulse flush while in_valid=1 with a 0x30 payload.
  - Required: next cycle out_valid=0 and ctrl_out=0; 0x30 never appears; in_ready=1.
- Counter saturation and clear:
  - Stimulus: CNT_W=4; stall 20 cycles.
  - Required: stall_cnt=15.
  - Stimulus: assert clr_stats during a stall.
  - Required: stall_cnt=0 next cycle.
- Randomised order check:
  - Stimulus: random in_valid, out_ready and sparse flush over 10k cycles.
  - Required: the output sequence equals the input sequence minus flushed entries; no loss and no duplication.
